// File: rtl/iob_regfile_wr_arb_pkg.sv
// Shared types and field offsets for the register-file write-port arbiter.
// The state encoding and the packed-request field offsets live here so that
// register-file integrators can slice {waddr, wstrb, wdata} consistently.
package iob_regfile_wr_arb_pkg;

    // Arbiter states; the encodings are visible to integrators.
    typedef enum logic {
        IOB_RWA_IDLE   = 1'b0,
        IOB_RWA_LOCKED = 1'b1
    } rwa_state_e;

    // Packed request layout: {waddr, wstrb, wdata}, wdata in the LSBs.
    localparam int RWA_WDATA_LSB = 0;

    function automatic int rwa_wstrb_lsb(input int wdata_w);
        return wdata_w;
    endfunction

    function automatic int rwa_waddr_lsb(input int wdata_w, input int wstrb_w);
        return wdata_w + wstrb_w;
    endfunction

    function automatic int rwa_req_w(input int waddr_w, input int wstrb_w, input int wdata_w);
        return waddr_w + wstrb_w + wdata_w;
    endfunction

endpackage

// File: rtl/iob_rr_sel.sv
// Combinational round-robin selector: scans the request vector starting at
// ptr_i and wrapping modulo N, returning the first hit as a one-hot grant and
// as an index. Purely combinational so it can be reused by other arbiters.
// ptr_i is expected to stay below N.
module iob_rr_sel #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Rotate-and-priority-encode: first requester at or after the pointer wins.
    always_comb begin
        int  k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/iob_regfile_wr_arb.sv
// Round-robin write-port arbiter for the two-port register file.
// Shares the single write port among N_REQ valid/ready requesters, with
// optional locked bursts of up to MAX_BURST beats per grant. The output
// register drives the register file's wen_i and write request directly.
//
// Optional feature macro: IOB_REGFILE_WR_ARB_PRIO_EN
//   defined   - in IDLE requester 0 wins whenever it is valid (never
//               preempts a LOCKED owner); the pointer still advances.
//   undefined - pure round-robin.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// IOB_RWA_IDLE   | round-robin arbitration among all valid requesters
// IOB_RWA_LOCKED | owner holds the port for a burst; others are blocked
module iob_regfile_wr_arb
    import iob_regfile_wr_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int WADDR_W   = 4,
    parameter int WDATA_W   = 32,
    parameter int WSTRB_W   = WDATA_W / 8,
    parameter int MAX_BURST = 4,
    parameter int REQ_W     = rwa_req_w(WADDR_W, WSTRB_W, WDATA_W)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cke_i,
    input  logic [N_REQ-1:0]           valid_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*REQ_W-1:0]     req_i,
    output logic [N_REQ-1:0]           ready_o,
    output logic                       wen_o,
    output logic [REQ_W-1:0]           wreq_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(N_REQ);
    // Counter holds values 0..MAX_BURST-1; sized so MAX_BURST=1 still has a bit.
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    rwa_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [REQ_W-1:0]  wreq_q, wreq_d;

    logic [N_REQ-1:0]  sel_gnt;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;

    logic [N_REQ-1:0]  ready;
    logic              accept;
    logic [IDX_W-1:0]  win_idx;

    iob_rr_sel #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_sel (
        .req_i (valid_i),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    // Next-state, grant and accept decode; nothing is granted under reset or
    // when the clock enable is low, so a held wen_o never duplicates a write.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        win_idx = owner_q;
        ready   = '0;
        if (cke_i && !rst_i) begin
            case (state_q)
                IOB_RWA_IDLE: begin
                    if (sel_any) begin
                        win_idx = sel_idx;
`ifdef IOB_REGFILE_WR_ARB_PRIO_EN
                        if (valid_i[0]) begin
                            win_idx = '0;
                        end
`endif
                        accept         = 1'b1;
                        ready[win_idx] = 1'b1;
                        ptr_d          = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
                        owner_d        = win_idx;
                        if (lock_i[win_idx] && (MAX_BURST > 1)) begin
                            state_d = IOB_RWA_LOCKED;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                IOB_RWA_LOCKED: begin
                    if (valid_i[owner_q]) begin
                        accept         = 1'b1;
                        ready[owner_q] = 1'b1;
                        if (lock_i[owner_q] && (cnt_q < CNT_LAST)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            state_d = IOB_RWA_IDLE;
                            cnt_d   = '0;
                        end
                    end else if (!lock_i[owner_q]) begin
                        state_d = IOB_RWA_IDLE;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // Output stage: load the winning request on accept, otherwise drop wen.
    always_comb begin
        wen_d  = accept;
        wreq_d = wreq_q;
        if (accept) begin
            wreq_d = req_i[int'(win_idx)*REQ_W +: REQ_W];
        end
    end

    // State and output registers: sync reset first, then clock-enabled update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IOB_RWA_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            wreq_q  <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            wreq_q  <= wreq_d;
        end
    end

    assign ready_o = ready;
    assign wen_o   = wen_q;
    assign wreq_o  = wreq_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q == IOB_RWA_LOCKED);

endmodule

// File: tb/tb_iob_regfile_wr_arb.sv
// Directed bench for iob_regfile_wr_arb with N_REQ=3, MAX_BURST=4.
// Build with IOB_REGFILE_WR_ARB_PRIO_EN defined to exercise the priority variant.
module tb_iob_regfile_wr_arb;

    localparam int N_REQ     = 3;
    localparam int WADDR_W   = 4;
    localparam int WDATA_W   = 32;
    localparam int WSTRB_W   = 4;
    localparam int MAX_BURST = 4;
    localparam int REQ_W     = WADDR_W + WSTRB_W + WDATA_W;

    localparam logic [REQ_W-1:0] D0 = {4'h1, 4'hF, 32'h1111_0000};
    localparam logic [REQ_W-1:0] D1 = {4'h2, 4'h3, 32'h2222_0001};
    localparam logic [REQ_W-1:0] D2 = {4'h3, 4'hC, 32'h3333_0002};
    localparam logic [REQ_W-1:0] DZ = '0;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     cke_i;
    logic [N_REQ-1:0]         valid_i;
    logic [N_REQ-1:0]         lock_i;
    logic [N_REQ*REQ_W-1:0]   req_i;
    logic [N_REQ-1:0]         ready_o;
    logic                     wen_o;
    logic [REQ_W-1:0]         wreq_o;
    logic [1:0]               owner_o;
    logic                     busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    iob_regfile_wr_arb #(
        .N_REQ     (N_REQ),
        .WADDR_W   (WADDR_W),
        .WDATA_W   (WDATA_W),
        .WSTRB_W   (WSTRB_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cke_i   (cke_i),
        .valid_i (valid_i),
        .lock_i  (lock_i),
        .req_i   (req_i),
        .ready_o (ready_o),
        .wen_o   (wen_o),
        .wreq_o  (wreq_o),
        .owner_o (owner_o),
        .busy_o  (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive valid/lock, check combinational ready, then check the
    // registered outputs just after the rising edge.
    task automatic cyc(input string tag, input logic [2:0] v, input logic [2:0] l,
                       input logic [2:0] er, input logic ew, input logic [1:0] eo,
                       input logic eb, input logic [REQ_W-1:0] ewq);
        valid_i = v;
        lock_i  = l;
        #1;
        chk({tag, " ready"}, 64'(ready_o), 64'(er));
        @(posedge clk_i);
        #1;
        chk({tag, " wen"},   64'(wen_o),   64'(ew));
        chk({tag, " owner"}, 64'(owner_o), 64'(eo));
        chk({tag, " busy"},  64'(busy_o),  64'(eb));
        chk({tag, " wreq"},  64'(wreq_o),  64'(ewq));
    endtask

    initial begin
        rst_i   = 1'b1;
        cke_i   = 1'b1;
        valid_i = '0;
        lock_i  = '0;
        req_i   = {D2, D1, D0};
        @(posedge clk_i);
        #1;

        // reset with all requesters valid
        cyc("rst0", 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, DZ);
        cyc("rst1", 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, DZ);
        rst_i = 1'b0;

`ifdef IOB_REGFILE_WR_ARB_PRIO_EN
        cyc("p0",  3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("p1",  3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("p2",  3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("pl1", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("pl2", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("pl3", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("pl4", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b0, D1);
        cyc("pe",  3'b111, 3'b010, 3'b001, 1'b1, 2'd0, 1'b0, D0);
`else
        // round-robin, first grant after reset goes to requester 0
        cyc("rr0", 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("rr1", 3'b111, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0, D1);
        cyc("rr2", 3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0, D2);
        cyc("rr3", 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("rr4", 3'b111, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0, D1);
        cyc("rr5", 3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0, D2);
        cyc("idl", 3'b000, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0, D2);

        // move pointer to 1, then burst cap for requester 1
        cyc("pre", 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
        cyc("bc1", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("bc2", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("bc3", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("bc4", 3'b111, 3'b010, 3'b010, 1'b1, 2'd1, 1'b0, D1);
        cyc("bc5", 3'b111, 3'b010, 3'b100, 1'b1, 2'd2, 1'b0, D2);
        cyc("bc6", 3'b111, 3'b010, 3'b001, 1'b1, 2'd0, 1'b0, D0);

        // bubble in a locked burst, then release with valid low
        cyc("bb0", 3'b100, 3'b100, 3'b100, 1'b1, 2'd2, 1'b1, D2);
        cyc("bg1", 3'b000, 3'b100, 3'b000, 1'b0, 2'd2, 1'b1, D2);
        cyc("bg2", 3'b000, 3'b100, 3'b000, 1'b0, 2'd2, 1'b1, D2);
        cyc("brs", 3'b100, 3'b100, 3'b100, 1'b1, 2'd2, 1'b1, D2);
        cyc("brl", 3'b000, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0, D2);
        cyc("bnx", 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);

        // clock enable low mid-burst freezes everything including cnt
        cyc("ck1", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("ck2", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cke_i = 1'b0;
        cyc("cf1", 3'b111, 3'b010, 3'b000, 1'b1, 2'd1, 1'b1, D1);
        cyc("cf2", 3'b111, 3'b010, 3'b000, 1'b1, 2'd1, 1'b1, D1);
        cyc("cf3", 3'b111, 3'b010, 3'b000, 1'b1, 2'd1, 1'b1, D1);
        cke_i = 1'b1;
        cyc("ck3", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        cyc("ck4", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b0, D1);

        // reset aborts a burst in progress
        cyc("mr0", 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, D1);
        rst_i = 1'b1;
        cyc("mr1", 3'b010, 3'b010, 3'b000, 1'b0, 2'd0, 1'b0, DZ);
        rst_i = 1'b0;
        cyc("mr2", 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0, D0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
